// File: rtl/pipelined_cla_addsub.sv
// Segmented carry-lookahead adder/subtractor, one SEG-bit segment per stage.
// Ports: Clk/Reset(async low), in_valid/in_ready, A/B/Cin/Sub, out_valid/out_ready, Sum/CO/OV/Z.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV,
  output logic             Z
);

  localparam int NSEG = WIDTH / SEG;
  localparam int NG   = SEG / 4;

  // Two-level lookahead: 4-bit groups, then group P/G across the segment.
  // Returns {carry_out, sum}.
  function automatic logic [SEG:0] cla_seg(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           ci
  );
    logic [SEG-1:0] p, g, s;
    logic [NG-1:0]  gp, gg;
    logic [NG:0]    gc;
    logic           c, t;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (&p[4*j+2 +: 2] & g[4*j+1])
            | (&p[4*j+1 +: 3] & g[4*j]);
    end
    for (int j = 0; j <= NG; j++) begin
      c = ci;
      for (int m = 0; m < j; m++) c &= gp[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t &= gp[m];
        c |= t;
      end
      gc[j] = c;
    end
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < 4; k++) begin
        c = gc[j];
        for (int m = 0; m < k; m++) c &= p[4*j+m];
        for (int i = 0; i < k; i++) begin
          t = g[4*j+i];
          for (int m = i + 1; m < k; m++) t &= p[4*j+m];
          c |= t;
        end
        s[4*j+k] = p[4*j+k] ^ c;
      end
    end
    return {gc[NG], s};
  endfunction

  logic             stall;
  logic [NSEG-1:0]  v_q, c_q, sub_q;
  logic [NSEG-1:0]  v_n, c_n, sub_n, cm_n;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] a_n [NSEG];
  logic [WIDTH-1:0] b_n [NSEG];
  logic [WIDTH-1:0] s_n [NSEG];
  logic             co_q, ov_q, z_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Operands shift right one segment per stage so the live segment is
  // always at the bottom; the sum fills in from the top and ends aligned.
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    logic [WIDTH-1:0] a_i, b_i, s_i;
    logic             sub_i, c_i;
    logic [SEG-1:0]   bx;
    logic [SEG:0]     r;
    if (k == 0) begin : g_first
      assign a_i    = A;
      assign b_i    = B;
      assign s_i    = '0;
      assign sub_i  = Sub;
      assign c_i    = Cin ^ Sub;
      assign v_n[k] = in_valid;
    end else begin : g_next
      assign a_i    = a_q[k-1];
      assign b_i    = b_q[k-1];
      assign s_i    = s_q[k-1];
      assign sub_i  = sub_q[k-1];
      assign c_i    = c_q[k-1];
      assign v_n[k] = v_q[k-1];
    end
    assign bx       = b_i[SEG-1:0] ^ {SEG{sub_i}};
    assign r        = cla_seg(a_i[SEG-1:0], bx, c_i);
    assign a_n[k]   = a_i >> SEG;
    assign b_n[k]   = b_i >> SEG;
    assign s_n[k]   = (WIDTH'(r[SEG-1:0]) << (WIDTH - SEG)) | (s_i >> SEG);
    assign sub_n[k] = sub_i;
    assign c_n[k]   = r[SEG];
    // carry into the segment MSB, recovered from its sum bit
    assign cm_n[k]  = r[SEG-1] ^ a_i[SEG-1] ^ bx[SEG-1];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v_q   <= '0;
      c_q   <= '0;
      sub_q <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
      z_q   <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q   <= v_n;
      c_q   <= c_n;
      sub_q <= sub_n;
      co_q  <= c_n[NSEG-1];
      ov_q  <= cm_n[NSEG-1] ^ c_n[NSEG-1];
      z_q   <= (s_n[NSEG-1] == '0);
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign Sum       = s_q[NSEG-1];
  assign CO        = co_q;
  assign OV        = ov_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: vector table, directed stall/reset
// sequences and a random stream against an arithmetic reference.
module tb_pipelined_cla_addsub;

  localparam int W  = 16;
  localparam int SG = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         CO, OV, Z;

  pipelined_cla_addsub #(.WIDTH(W), .SEG(SG)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .CO(CO), .OV(OV), .Z(Z)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         z;
  } res_t;

  typedef struct {
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         s;
    res_t         exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  res_t q[$];
  logic stl_prev = 1'b0;
  res_t prev_out = '0;

  // Reference: exact integer arithmetic, then reduce to the flags.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    res_t   r;
    longint ua, ub, sa, sb, c, eu, es, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    c   = ci ? 1 : 0;
    lim = longint'(1) << (W - 1);
    if (s) begin
      eu   = ua - ub - c;
      es   = sa - sb - c;
      r.co = (eu >= 0);
    end else begin
      eu   = ua + ub + c;
      es   = sa + sb + c;
      r.co = (eu >= (longint'(1) << W));
    end
    r.sum = eu[W-1:0];
    r.ov  = (es < -lim) || (es >= lim);
    r.z   = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, then inspect the handshake the next
  // posedge will perform.
  task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic s, input logic ordy);
    res_t got, e;
    @(negedge Clk);
    in_valid = v;
    A = a;
    B = b;
    Cin = ci;
    Sub = s;
    out_ready = ordy;
    #1;
    got = {Sum, CO, OV, Z};
    if (stl_prev) begin
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_hold", 32'(got), 32'(prev_out));
    end
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      chk("out_present", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", 32'(got), 32'(e));
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, ci, s));
      n_acc++;
    end
    stl_prev = out_valid && !out_ready;
    prev_out = got;
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   cyc;
    int   start;

    tbl[0] = '{"add_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{"seg_carry",   16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{"sub",         16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
    tbl[5] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFD, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{"sub_zero",    16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{"add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0, 1'b0}};
    tbl[8] = '{"add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_outputs", 32'({Sum, CO, OV, Z}), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge Clk);
    Reset = 1'b1;

    // table vectors, each with a latency check
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, 1'b1);
      idle(1'b1);
      chk({tbl[i].nm, "_early"}, 32'(out_valid), 32'(0));
      idle(1'b1);
      chk({tbl[i].nm, "_valid"}, 32'(out_valid), 32'(1));
      chk(tbl[i].nm, 32'({Sum, CO, OV, Z}), 32'(tbl[i].exp));
    end
    idle(1'b1);

    // backpressure: 4 back-to-back adds, 3-cycle stall
    tick(1'b1, 16'h0101, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h0202, 16'h00FF, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h0303, 16'hFF00, 1'b1, 1'b0, 1'b0);
    chk("bp_out_valid", 32'(out_valid), 32'(1));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    tick(1'b1, 16'h0303, 16'hFF00, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0303, 16'hFF00, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0303, 16'hFF00, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 16'h0404, 16'h7C00, 1'b0, 1'b0, 1'b1);
    chk("bp_out1", 32'(out_valid), 32'(1));
    idle(1'b1);
    chk("bp_out2", 32'(out_valid), 32'(1));
    idle(1'b1);
    chk("bp_out3", 32'(out_valid), 32'(1));
    idle(1'b1);
    chk("bp_empty", 32'(out_valid), 32'(0));
    chk("bp_drain", 32'(q.size()), 32'(0));

    // reset mid-stream with a stalled result at the output
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    @(negedge Clk);
    in_valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_outputs", 32'({Sum, CO, OV, Z}), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    q.delete();
    stl_prev = 1'b0;
    idle(1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("no_stale", 32'(out_valid), 32'(0));
    end
    tick(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("post_rst_early", 32'(out_valid), 32'(0));
    idle(1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'(1));
    chk("post_rst_sum", 32'(Sum), 32'(16'h9999));
    idle(1'b1);

    // random stream with random valid/ready
    start = n_acc;
    cyc = 0;
    while ((n_acc - start) < 10000 && cyc < 60000) begin
      tick(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
      cyc++;
    end
    chk("rand_accepted", 32'(n_acc - start), 32'(10000));
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      idle(1'b1);
      cyc++;
    end
    chk("rand_drain", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of SEG.
REQ-002 The block SHALL have parameter SEG, default 8, bits per pipeline segment; legal values are multiples of 4 that divide WIDTH.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  input transaction present.
REQ-006 in_ready  out  1  block accepts input this cycle.
REQ-007 A  in  WIDTH  operand A.
REQ-008 B  in  WIDTH  operand B.
REQ-009 Cin  in  1  carry-in (add) / borrow-in (sub).
REQ-010 Sub  in  1  0 = add, 1 = subtract.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 Sum  out  WIDTH  result.
REQ-014 CO  out  1  raw carry-out of MSB (sub: 1 = no borrow).
REQ-015 OV  out  1  two's-complement overflow.
REQ-016 Z  out  1  Sum equals zero.

Function
REQ-017 The block SHALL compute Sum/CO = A + (B XOR {WIDTH{Sub}}) + (Cin XOR Sub), modulo 2^WIDTH, with CO as bit WIDTH of that sum.
REQ-018 Within each segment, the block SHALL use 4-bit groups with bit p = a^b, g = a&b, fully lookahead intra-group carries, and group PG/GG combined by a second-level lookahead; no ripple across groups within a segment.
REQ-019 The block SHALL use NSEG = WIDTH/SEG pipeline stages; stage k adds segment k using the registered carry from stage k-1, and stage 0 uses Cin XOR Sub.
REQ-020 The block SHALL skew operand segment k (and Sub) through k register stages before use, and deskew completed lower segments so that all Sum bits, CO, OV and Z of one transaction appear together.
REQ-021 Latency SHALL be exactly NSEG cycles from an accepted input (in_valid & in_ready at edge t) to out_valid high after edge t+NSEG-1 when there is no stall; throughput SHALL be one transaction per cycle.
REQ-022 OV SHALL equal carry-into-MSB XOR carry-out-of-MSB; Z SHALL be computed from the final aligned Sum.
REQ-023 Stall: stall = out_valid & ~out_ready; during stall the whole pipeline SHALL freeze (valid bits, data, carries) and Sum/CO/OV/Z/out_valid SHALL hold stable.
REQ-024 The block SHALL drive in_ready = ~stall, combinationally; inputs presented while in_ready=0 are not consumed.
REQ-025 Each stage SHALL carry a valid bit; bubbles (in_valid=0 when accepted) SHALL propagate as invalid stages and SHALL NOT raise out_valid.
REQ-026 When out_valid & out_ready and a new result is in the last-but-one stage in the same cycle, the result SHALL advance with no bubble inserted.
REQ-027 Transactions SHALL exit in acceptance order with none dropped or duplicated.
REQ-028 For NSEG = 1 the block SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-029 On Reset low, all valid bits, data and carry registers SHALL clear immediately: out_valid=0, Sum=0, CO=0, OV=0, Z=0.
REQ-030 in_ready SHALL be 1 while Reset is low.
REQ-031 In-flight transactions at reset assertion SHALL be discarded; the first accepted input after deassertion SHALL emerge after NSEG cycles.

Verification (WIDTH=16, SEG=8, latency 2)
REQ-032 Reset scenario: assert Reset low mid-stream -> out_valid=0 and Sum=0 at once, in_ready=1; after release, no stale result appears.
REQ-033 Add carry scenario: A=FFFF, B=0001, Cin=0, Sub=0 -> two cycles later Sum=0000, CO=1, OV=0, Z=1.
REQ-034 Add overflow scenario: A=7FFF, B=0001, Cin=0, Sub=0 -> Sum=8000, CO=0, OV=1, Z=0; and A=00FF, B=0001 -> Sum=0100, which checks the segment-boundary carry.
REQ-035 Subtract scenario: A=0005, B=0007, Cin=0, Sub=1 -> Sum=FFFE, CO=0, OV=0.
REQ-036 Subtract overflow scenario: A=8000, B=0001, Cin=0, Sub=1 -> Sum=7FFF, CO=1, OV=1.
REQ-037 Borrow-in scenario: A=0005, B=0007, Cin=1, Sub=1 -> Sum=FFFD.
REQ-038 Backpressure scenario: stream 4 back-to-back adds, hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 and outputs stable during the stall; all 4 results then emerge in order, one per cycle.
REQ-039 Random scenario: 10k random A/B/Cin/Sub with random in_valid/out_ready -> every output matches the reference model, in order.
